// File: rtl/viterbi_argmax_stream.sv
// Streaming argmax over NUM_STATES path metrics, LANES per beat.
// Ports: clk, reset (sync, active-low), flush, in_* / out_* valid-ready
//   streams, max_metric/max_index/max_onehot result, capture_en, last_state.
module viterbi_argmax_stream #(
    parameter int P_SIZE     = 32,
    parameter int NUM_STATES = 11,
    parameter int IDX_W      = 4,
    parameter int LANES      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*P_SIZE-1:0] in_metric,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_SIZE-1:0]       max_metric,
    output logic [IDX_W-1:0]        max_index,
    output logic [NUM_STATES-1:0]   max_onehot,
    input  logic                    capture_en,
    output logic [IDX_W-1:0]        last_state
);

    localparam int BEATS = (NUM_STATES + LANES - 1) / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [P_SIZE-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;

    logic [P_SIZE-1:0] beat_max;
    logic [IDX_W-1:0]  beat_idx;
    logic [P_SIZE-1:0] nxt_max;
    logic [IDX_W-1:0]  nxt_idx;
    logic              accept;
    logic              last_beat;
    int                base;

    // Lane reduction: lane 0 is always a real state, so it seeds the
    // search; later lanes win only when strictly greater (low index on tie).
    always_comb begin
        base     = int'(cnt) * LANES;
        beat_max = in_metric[0 +: P_SIZE];
        beat_idx = IDX_W'(base);
        for (int k = 1; k < LANES; k++) begin
            if ((base + k) < NUM_STATES &&
                in_metric[k*P_SIZE +: P_SIZE] > beat_max) begin
                beat_max = in_metric[k*P_SIZE +: P_SIZE];
                beat_idx = IDX_W'(base + k);
            end
        end
    end

    // First beat of a step seeds; later beats replace only when greater.
    always_comb begin
        nxt_max = run_max;
        nxt_idx = run_idx;
        if (state == IDLE || beat_max > run_max) begin
            nxt_max = beat_max;
            nxt_idx = beat_idx;
        end
    end

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            max_metric <= '0;
            max_index  <= '0;
            max_onehot <= '0;
            last_state <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        run_max <= nxt_max;
                        run_idx <= nxt_idx;
                        if (last_beat) begin
                            state      <= DONE;
                            cnt        <= '0;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            max_metric <= nxt_max;
                            max_index  <= nxt_idx;
                            max_onehot <= NUM_STATES'(1) << nxt_idx;
                        end else begin
                            state <= ACCUM;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        if (capture_en) begin
                            last_state <= max_index;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_argmax_stream.sv
// Directed self-checking bench for viterbi_argmax_stream.
// Covers defaults, ties, backpressure, flush, reset and LANES=1/11 builds.
module tb_viterbi_argmax_stream;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_metric;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  max_metric;
    logic [3:0]   max_index;
    logic [10:0]  max_onehot;
    logic         capture_en;
    logic [3:0]   last_state;

    logic         in_valid1, in_ready1, out_valid1;
    logic [31:0]  in_metric1, max_metric1;
    logic [3:0]   max_index1, last_state1;
    logic [10:0]  max_onehot1;

    logic         in_valid11, in_ready11, out_valid11;
    logic [351:0] in_metric11;
    logic [31:0]  max_metric11;
    logic [3:0]   max_index11, last_state11;
    logic [10:0]  max_onehot11;

    logic         zero;
    logic         one;

    logic [31:0]  vec [11];
    logic [31:0]  xval;
    int           checks;
    int           failures;

    viterbi_argmax_stream dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_metric(in_metric),
        .out_valid(out_valid), .out_ready(out_ready),
        .max_metric(max_metric), .max_index(max_index),
        .max_onehot(max_onehot), .capture_en(capture_en),
        .last_state(last_state)
    );

    viterbi_argmax_stream #(.LANES(1)) dut1 (
        .clk(clk), .reset(reset), .flush(zero),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_metric(in_metric1),
        .out_valid(out_valid1), .out_ready(one),
        .max_metric(max_metric1), .max_index(max_index1),
        .max_onehot(max_onehot1), .capture_en(one),
        .last_state(last_state1)
    );

    viterbi_argmax_stream #(.LANES(11)) dut11 (
        .clk(clk), .reset(reset), .flush(zero),
        .in_valid(in_valid11), .in_ready(in_ready11), .in_metric(in_metric11),
        .out_valid(out_valid11), .out_ready(one),
        .max_metric(max_metric11), .max_index(max_index11),
        .max_onehot(max_onehot11), .capture_en(one),
        .last_state(last_state11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input int b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_metric[k*32 +: 32] = ((b*4 + k) < 11) ? vec[b*4 + k] : xval;
        end
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_beat timeout beat=%0d", b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_beat1(input int s);
        int n;
        n = 0;
        @(negedge clk);
        in_valid1  = 1'b1;
        in_metric1 = vec[s];
        while (!in_ready1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_beat1 timeout s=%0d", s);
        end
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic send_beat11();
        int n;
        n = 0;
        @(negedge clk);
        in_valid11 = 1'b1;
        for (int k = 0; k < 11; k++) in_metric11[k*32 +: 32] = vec[k];
        while (!in_ready11 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_beat11 timeout");
        end
        @(posedge clk);
        #1 in_valid11 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b want 0 0",
                     in_ready, out_valid);
        end
        checks++;
        if (max_metric !== 32'd0 || max_index !== 4'd0 ||
            max_onehot !== 11'd0 || last_state !== 4'd0) begin
            failures++;
            $display("FAIL reset_out m=%h i=%0d oh=%h ls=%0d want zeros",
                     max_metric, max_index, max_onehot, last_state);
        end
        reset = 1'b1;
    endtask

    task automatic test_defaults(input logic [31:0] x);
        vec = '{5, 9, 3, 9, 7, 2, 11, 4, 1, 11, 6};
        xval = x;
        out_ready = 1'b1;
        capture_en = 1'b1;
        send_beat(0);
        send_beat(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL def_early out_valid=%b want 0", out_valid);
        end
        send_beat(2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || max_metric !== 32'd11 ||
            max_index !== 4'd6 || max_onehot !== 11'h040) begin
            failures++;
            $display("FAIL def_result x=%h v=%b m=%0d i=%0d oh=%h want 1 11 6 040",
                     x, out_valid, max_metric, max_index, max_onehot);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || last_state !== 4'd6 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL def_consume v=%b ls=%0d rdy=%b want 0 6 1",
                     out_valid, last_state, in_ready);
        end
    endtask

    task automatic test_ties();
        for (int i = 0; i < 11; i++) vec[i] = 32'h8000_0000;
        xval = 32'hFFFF_FFFF;
        for (int b = 0; b < 3; b++) send_beat(b);
        @(negedge clk);
        checks++;
        if (max_index !== 4'd0 || max_onehot !== 11'h001 ||
            max_metric !== 32'h8000_0000) begin
            failures++;
            $display("FAIL tie_all i=%0d oh=%h m=%h want 0 001 80000000",
                     max_index, max_onehot, max_metric);
        end
        for (int i = 0; i < 11; i++) vec[i] = 32'd0;
        vec[3] = 32'hFFFF_FFFF;
        vec[9] = 32'hFFFF_FFFF;
        for (int b = 0; b < 3; b++) send_beat(b);
        @(negedge clk);
        checks++;
        if (max_index !== 4'd3 || max_onehot !== 11'h008) begin
            failures++;
            $display("FAIL tie_3_9 i=%0d oh=%h want 3 008", max_index, max_onehot);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 11; i++) vec[i] = 32'(10 - i);
        xval = 32'd0;
        out_ready = 1'b0;
        capture_en = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(b);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_metric !== 32'd10 ||
                max_index !== 4'd0 || max_onehot !== 11'h001) begin
                failures++;
                $display("FAIL bp_hold c=%0d v=%b rdy=%b m=%0d i=%0d oh=%h want 1 0 10 0 001",
                         c, out_valid, in_ready, max_metric, max_index, max_onehot);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || last_state !== 4'd3) begin
            failures++;
            $display("FAIL bp_release v=%b ls=%0d want 0 3", out_valid, last_state);
        end
        capture_en = 1'b1;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 11; i++) vec[i] = 32'd100;
        send_beat(0);
        send_beat(1);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || last_state !== 4'd3) begin
                failures++;
                $display("FAIL flush_idle c=%0d v=%b rdy=%b ls=%0d want 0 1 3",
                         c, out_valid, in_ready, last_state);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 11; i++) vec[i] = 32'(i);
        for (int b = 0; b < 3; b++) send_beat(b);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || max_index !== 4'd10 ||
            max_onehot !== 11'h400 || max_metric !== 32'd10) begin
            failures++;
            $display("FAIL flush_next v=%b i=%0d oh=%h m=%0d want 1 10 400 10",
                     out_valid, max_index, max_onehot, max_metric);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_beat(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || last_state !== 4'd0 ||
            in_ready !== 1'b0 || max_index !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid v=%b ls=%0d rdy=%b i=%0d want 0 0 0 0",
                     out_valid, last_state, in_ready, max_index);
        end
        reset = 1'b1;
        for (int i = 0; i < 11; i++) vec[i] = 32'd1;
        vec[2] = 32'd20;
        send_beat(0);
        send_beat(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_cnt v=%b want 0", out_valid);
        end
        send_beat(2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || max_index !== 4'd2 || max_metric !== 32'd20) begin
            failures++;
            $display("FAIL rst_step v=%b i=%0d m=%0d want 1 2 20",
                     out_valid, max_index, max_metric);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        vec = '{5, 9, 3, 9, 7, 2, 11, 4, 1, 11, 6};
        for (int s = 0; s < 10; s++) send_beat1(s);
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL l1_early v=%b want 0", out_valid1);
        end
        send_beat1(10);
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b1 || max_index1 !== 4'd6 ||
            max_metric1 !== 32'd11 || max_onehot1 !== 11'h040) begin
            failures++;
            $display("FAIL l1_result v=%b i=%0d m=%0d oh=%h want 1 6 11 040",
                     out_valid1, max_index1, max_metric1, max_onehot1);
        end
        send_beat11();
        @(negedge clk);
        checks++;
        if (out_valid11 !== 1'b1 || max_index11 !== 4'd6 ||
            max_metric11 !== 32'd11 || max_onehot11 !== 11'h040) begin
            failures++;
            $display("FAIL l11_result v=%b i=%0d m=%0d oh=%h want 1 6 11 040",
                     out_valid11, max_index11, max_metric11, max_onehot11);
        end
        @(negedge clk);
        checks++;
        if (last_state1 !== 4'd6 || last_state11 !== 4'd6 || out_valid11 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_ls ls1=%0d ls11=%0d v11=%b want 6 6 0",
                     last_state1, last_state11, out_valid11);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        zero = 1'b0;
        one = 1'b1;
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_metric = '0;
        out_ready = 1'b1;
        capture_en = 1'b1;
        in_valid1 = 1'b0;
        in_metric1 = '0;
        in_valid11 = 1'b0;
        in_metric11 = '0;
        xval = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_defaults(32'd0);
        test_defaults(32'hFFFF_FFFF);
        test_ties();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_argmax_stream.md
Name: viterbi_argmax_stream

Overview:
Streaming argmax unit for the Viterbi decoder's per-step path-metric reduction. It accepts NUM_STATES path metrics over several beats of LANES metrics each and keeps a running maximum and its index. Per step it emits the max metric, its state index and a one-hot predecessor address. It also holds a last-state register that traceback uses as its start point. It generalises the fixed 11-input combinational max tree to any state count and lane width, with valid/ready handshakes, a deterministic tie rule and a flush.

Parameters:
P_SIZE, 32, metric width in bits (unsigned)
NUM_STATES, 11, number of POS/states reduced per step (>=2)
IDX_W, 4, state index width; must satisfy 2**IDX_W >= NUM_STATES
LANES, 4, metrics accepted per beat (1..NUM_STATES)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous abort of the current step; no result produced
in_valid  input  1  beat of metrics present
in_ready  output  1  beat accepted when in_valid && in_ready
in_metric  input  LANES*P_SIZE  lane k in bits [k*P_SIZE +: P_SIZE]; lane k of beat b is state b*LANES+k
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
max_metric  output  P_SIZE  maximum metric of the step
max_index  output  IDX_W  index of the maximum
max_onehot  output  NUM_STATES  one-hot decode of max_index (new predecessor address)
capture_en  input  1  load last_state when the result is consumed
last_state  output  IDX_W  registered final-state index for traceback

Behaviour:
- BEATS = ceil(NUM_STATES/LANES). In the final beat, lanes whose state index is >= NUM_STATES are ignored (masked), whatever data they carry.
- Reset (reset==0 at posedge): FSM goes to IDLE, beat counter 0, and the running max and index are 0. Outputs: out_valid=0, max_metric=0, max_index=0, max_onehot=0, last_state=0, in_ready=0 during the reset cycle.
- FSM states:
  - IDLE: in_ready=1. An accepted beat seeds the running max with that beat's lane reduction, counter becomes 1, and the FSM goes to ACCUM. If BEATS==1 it goes straight to DONE.
  - ACCUM: in_ready=1. Each accepted beat compares its lane reduction against the running max and increments the counter. The beat where counter==BEATS-1 is the last beat; the FSM then goes to DONE and the counter wraps to 0.
  - DONE: in_ready=0 and out_valid=1. max_metric, max_index and max_onehot stay stable until out_valid && out_ready, then the FSM returns to IDLE.
- Latency: out_valid rises on the clock after the last beat is accepted. With in_valid held high and out_ready=1, throughput is one step per BEATS+1 cycles.
- Comparison is unsigned. Ties go to the lower state index, both within a beat and against the running max: a later beat replaces the running max only when strictly greater.
- max_onehot = 1 << max_index; it is registered together with max_index.
- last_state: loads max_index on a cycle where out_valid && out_ready && capture_en; otherwise it holds. It is unaffected by flush.
- flush: highest priority after reset. From any state it returns the FSM to IDLE, clears the counter and out_valid, and the partial step is discarded. A beat presented in the same cycle is dropped. last_state is kept.
- Back-to-back: out_ready=1 in DONE returns the FSM to IDLE on the next edge. The next step's first beat can be accepted one cycle later (in_ready=0 in DONE).
- in_valid=0 mid-step: the FSM holds its state and counter indefinitely; there is no timeout.

Test Plan:
- Defaults. Beats {5,9,3,9}, {7,2,11,4}, {1,11,6,X}; out_ready=1, capture_en=1. Required: out_valid one cycle after beat 3, max_metric=11, max_index=6, max_onehot=11'h040, last_state=6. Lane 3 of beat 3 (state 11) is ignored even when X=0xFFFFFFFF.
- Ties. All 11 metrics = 0x80000000 -> max_index=0, max_onehot=11'h001. Metrics 3 and 9 both = 0xFFFFFFFF, others 0 -> max_index=3.
- Backpressure. out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. On release, out_valid drops the next cycle. With capture_en=0, last_state is unchanged.
- Flush. flush=1 after beat 2 -> no out_valid. A following full step {0..10 ascending} gives max_index=10.
- Reset. reset=0 mid-ACCUM -> next cycle out_valid=0, last_state=0, counter 0. A new step then completes normally.
- Parameter sweep LANES=1 and LANES=11. Same vectors -> identical results, with out_valid at beat 11+1 and beat 1+1 respectively.
